// File: rtl/truco_pkg.sv
// -----------------------------------------------------------------------------
// truco_pkg
// Shared definitions for the Truco hand controller:
//   - state_t    : controller state encoding
//   - team codes : T1, T2, TIE, NONE as carried on trick/bet/winner buses
//   - bet ladder : the stake values 1 -> 3 -> 6 -> 9 -> 12
//   - next_bet() : next rung of the ladder (12 stays at 12)
//   - valid_team(): true for a single-team code (T1 or T2)
// -----------------------------------------------------------------------------
package truco_pkg;

  typedef enum logic [1:0] {
    ST_TRICK     = 2'd0,
    ST_BET_PEND  = 2'd1,
    ST_AWARD     = 2'd2,
    ST_GAME_OVER = 2'd3
  } state_t;

  localparam logic [1:0] NONE = 2'b00;
  localparam logic [1:0] T1   = 2'b01;
  localparam logic [1:0] T2   = 2'b10;
  localparam logic [1:0] TIE  = 2'b11;

  localparam logic [3:0] BET_1  = 4'd1;
  localparam logic [3:0] BET_3  = 4'd3;
  localparam logic [3:0] BET_6  = 4'd6;
  localparam logic [3:0] BET_9  = 4'd9;
  localparam logic [3:0] BET_12 = 4'd12;

  // Next stake on the truco ladder; the top rung (and any off-ladder value) holds.
  function automatic logic [3:0] next_bet(input logic [3:0] value);
    logic [3:0] nxt;
    case (value)
      BET_1:   nxt = BET_3;
      BET_3:   nxt = BET_6;
      BET_6:   nxt = BET_9;
      BET_9:   nxt = BET_12;
      default: nxt = value;
    endcase
    return nxt;
  endfunction

  // A requester code is usable only if it names exactly one team.
  function automatic logic valid_team(input logic [1:0] team);
    return (team == T1) || (team == T2);
  endfunction

endpackage

// File: rtl/truco_hand_judge.sv
// -----------------------------------------------------------------------------
// truco_hand_judge
// Combinational hand judge. Given the trick results recorded so far (including
// the trick being played now) and the index of that trick, reports whether the
// hand is resolved and, if so, who won it.
// Ports:
//   res       in  3 x 2  trick results, res[i] for trick i (T1/T2/TIE)
//   trick_idx in  2      index of the trick just played (0..2)
//   decided   out 1      hand is resolved by this trick
//   winner    out 2      T1, T2, or NONE for a fully tied (void) hand
// -----------------------------------------------------------------------------
module truco_hand_judge
  import truco_pkg::*;
(
  input  logic [1:0] res [3],
  input  logic [1:0] trick_idx,
  output logic       decided,
  output logic [1:0] winner
);

  // Resolve the hand from the tricks played up to and including trick_idx.
  always_comb begin
    decided = 1'b0;
    winner  = NONE;
    case (trick_idx)
      2'd0: begin
        // A single trick never settles a hand.
        decided = 1'b0;
        winner  = NONE;
      end
      2'd1: begin
        if ((res[0] == TIE) && (res[1] == TIE)) begin
          decided = 1'b0;
          winner  = NONE;
        end else if (res[0] == TIE) begin
          // Tied first trick: the first decisive trick takes the hand.
          decided = 1'b1;
          winner  = res[1];
        end else if ((res[1] == TIE) || (res[1] == res[0])) begin
          // Two wins, or trick0 winner protected by a later tie.
          decided = 1'b1;
          winner  = res[0];
        end else begin
          // 1-1 split: play the third trick.
          decided = 1'b0;
          winner  = NONE;
        end
      end
      2'd2: begin
        // Only a 1-1 split or a double tie reaches the third trick.
        decided = 1'b1;
        if (res[2] != TIE) begin
          winner = res[2];
        end else if (res[0] != TIE) begin
          winner = res[0];
        end else begin
          winner = NONE;
        end
      end
      default: begin
        decided = 1'b0;
        winner  = NONE;
      end
    endcase
  end

endmodule

// File: rtl/truco_hand_ctrl.sv
// -----------------------------------------------------------------------------
// truco_hand_ctrl
// Sequences a Truco game: records trick results, resolves each hand through
// truco_hand_judge, runs the truco raise handshake on the 1-3-6-9-12 ladder and
// accumulates both team scores, saturating at WIN_SCORE.
// Ports:
//   clk, clr         clock (rising edge) and synchronous active-high reset
//   trick_valid/trick_winner  trick result pulse (01/10/11; 00 ignored)
//   bet_req/bet_team raise request pulse and requesting team
//   bet_accept/bet_fold       opponent answer to the pending raise
//   new_game         leave GAME_OVER with zeroed scores
//   score1/score2    team scores
//   hand_value       points at stake in the current hand
//   trick_idx        trick currently being played (0..2)
//   bet_pending      a raise awaits an answer
//   hand_done        one-cycle pulse after a hand's score update
//   hand_winner      winner of that hand (00 = void), valid with hand_done
//   game_over/game_winner     final result once a score reaches WIN_SCORE
// All outputs come straight from registers.
// -----------------------------------------------------------------------------
module truco_hand_ctrl
  import truco_pkg::*;
#(
  parameter int WIN_SCORE = 12,
  parameter int SCORE_W   = 5
)(
  input  logic               clk,
  input  logic               clr,
  input  logic               trick_valid,
  input  logic [1:0]         trick_winner,
  input  logic               bet_req,
  input  logic [1:0]         bet_team,
  input  logic               bet_accept,
  input  logic               bet_fold,
  input  logic               new_game,
  output logic [SCORE_W-1:0] score1,
  output logic [SCORE_W-1:0] score2,
  output logic [3:0]         hand_value,
  output logic [1:0]         trick_idx,
  output logic               bet_pending,
  output logic               hand_done,
  output logic [1:0]         hand_winner,
  output logic               game_over,
  output logic [1:0]         game_winner
);

  // One extra bit so score + stake cannot wrap before saturation.
  localparam int                SUM_W   = SCORE_W + 1;
  localparam logic [SUM_W-1:0]  WIN_EXT = SUM_W'(WIN_SCORE);

  state_t             state_r, state_nxt_s;
  logic [SCORE_W-1:0] score1_r, score1_nxt_s;
  logic [SCORE_W-1:0] score2_r, score2_nxt_s;
  logic [3:0]         hand_value_r, hand_value_nxt_s;
  logic [1:0]         trick_idx_r, trick_idx_nxt_s;
  logic [1:0]         res_r [3];
  logic [1:0]         res_nxt_s [3];
  logic [1:0]         res_new_s [3];
  logic [1:0]         last_raiser_r, last_raiser_nxt_s;
  logic [1:0]         requester_r, requester_nxt_s;
  logic [1:0]         award_team_r, award_team_nxt_s;
  logic               bet_pending_r, bet_pending_nxt_s;
  logic               hand_done_r, hand_done_nxt_s;
  logic [1:0]         hand_winner_r, hand_winner_nxt_s;
  logic               game_over_r, game_over_nxt_s;
  logic [1:0]         game_winner_r, game_winner_nxt_s;

  logic               judge_decided_s;
  logic [1:0]         judge_winner_s;
  logic [SUM_W-1:0]   sum1_s, sum2_s, sat1_s, sat2_s;
  logic               bet_ok_s;

  // A raise is legal below the top rung, from a real team, and not twice in a row by the same team.
  assign bet_ok_s = (hand_value_r < BET_12) && valid_team(bet_team) && (bet_team != last_raiser_r);

  // Trick results as they would be with the incoming trick written at trick_idx.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      if (trick_idx_r == 2'(i)) begin
        res_new_s[i] = trick_winner;
      end else begin
        res_new_s[i] = res_r[i];
      end
    end
  end

  truco_hand_judge u_judge (
    .res       (res_new_s),
    .trick_idx (trick_idx_r),
    .decided   (judge_decided_s),
    .winner    (judge_winner_s)
  );

  // Candidate scores after adding the stake, clamped at WIN_SCORE.
  always_comb begin
    sum1_s = SUM_W'(score1_r) + SUM_W'(hand_value_r);
    sum2_s = SUM_W'(score2_r) + SUM_W'(hand_value_r);
    if (sum1_s >= WIN_EXT) begin
      sat1_s = WIN_EXT;
    end else begin
      sat1_s = sum1_s;
    end
    if (sum2_s >= WIN_EXT) begin
      sat2_s = WIN_EXT;
    end else begin
      sat2_s = sum2_s;
    end
  end

  // Next-state and next-register logic for the game sequencer.
  always_comb begin
    state_nxt_s       = state_r;
    score1_nxt_s      = score1_r;
    score2_nxt_s      = score2_r;
    hand_value_nxt_s  = hand_value_r;
    trick_idx_nxt_s   = trick_idx_r;
    res_nxt_s         = res_r;
    last_raiser_nxt_s = last_raiser_r;
    requester_nxt_s   = requester_r;
    award_team_nxt_s  = award_team_r;
    bet_pending_nxt_s = bet_pending_r;
    hand_done_nxt_s   = 1'b0;
    hand_winner_nxt_s = NONE;
    game_over_nxt_s   = game_over_r;
    game_winner_nxt_s = game_winner_r;

    case (state_r)
      ST_TRICK: begin
        if (trick_valid) begin
          // A trick pulse always takes precedence over a raise in the same cycle.
          if (trick_winner != NONE) begin
            res_nxt_s = res_new_s;
            if (judge_decided_s) begin
              award_team_nxt_s = judge_winner_s;
              state_nxt_s      = ST_AWARD;
            end else begin
              trick_idx_nxt_s = trick_idx_r + 2'd1;
            end
          end else begin
            res_nxt_s = res_r;
          end
        end else if (bet_req && bet_ok_s) begin
          requester_nxt_s   = bet_team;
          bet_pending_nxt_s = 1'b1;
          state_nxt_s       = ST_BET_PEND;
        end else begin
          state_nxt_s = ST_TRICK;
        end
      end

      ST_BET_PEND: begin
        if (bet_fold) begin
          // Running from a raise concedes the hand at the stake before the raise.
          award_team_nxt_s  = requester_r;
          bet_pending_nxt_s = 1'b0;
          state_nxt_s       = ST_AWARD;
        end else if (bet_accept) begin
          hand_value_nxt_s  = next_bet(hand_value_r);
          last_raiser_nxt_s = requester_r;
          bet_pending_nxt_s = 1'b0;
          state_nxt_s       = ST_TRICK;
        end else begin
          state_nxt_s = ST_BET_PEND;
        end
      end

      ST_AWARD: begin
        if (award_team_r == T1) begin
          score1_nxt_s = SCORE_W'(sat1_s);
        end else if (award_team_r == T2) begin
          score2_nxt_s = SCORE_W'(sat2_s);
        end else begin
          score1_nxt_s = score1_r;
        end
        hand_done_nxt_s   = 1'b1;
        hand_winner_nxt_s = award_team_r;
        hand_value_nxt_s  = BET_1;
        trick_idx_nxt_s   = 2'd0;
        for (int i = 0; i < 3; i++) begin
          res_nxt_s[i] = NONE;
        end
        last_raiser_nxt_s = NONE;
        requester_nxt_s   = NONE;
        award_team_nxt_s  = NONE;
        if ((award_team_r == T1) && (sum1_s >= WIN_EXT)) begin
          game_over_nxt_s   = 1'b1;
          game_winner_nxt_s = T1;
          state_nxt_s       = ST_GAME_OVER;
        end else if ((award_team_r == T2) && (sum2_s >= WIN_EXT)) begin
          game_over_nxt_s   = 1'b1;
          game_winner_nxt_s = T2;
          state_nxt_s       = ST_GAME_OVER;
        end else begin
          state_nxt_s = ST_TRICK;
        end
      end

      ST_GAME_OVER: begin
        if (new_game) begin
          score1_nxt_s      = '0;
          score2_nxt_s      = '0;
          game_over_nxt_s   = 1'b0;
          game_winner_nxt_s = NONE;
          state_nxt_s       = ST_TRICK;
        end else begin
          state_nxt_s = ST_GAME_OVER;
        end
      end

      default: begin
        state_nxt_s = ST_TRICK;
      end
    endcase
  end

  // State and datapath registers with synchronous clear.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_r       <= ST_TRICK;
      score1_r      <= '0;
      score2_r      <= '0;
      hand_value_r  <= BET_1;
      trick_idx_r   <= 2'd0;
      for (int i = 0; i < 3; i++) begin
        res_r[i] <= NONE;
      end
      last_raiser_r <= NONE;
      requester_r   <= NONE;
      award_team_r  <= NONE;
      bet_pending_r <= 1'b0;
      hand_done_r   <= 1'b0;
      hand_winner_r <= NONE;
      game_over_r   <= 1'b0;
      game_winner_r <= NONE;
    end else begin
      state_r       <= state_nxt_s;
      score1_r      <= score1_nxt_s;
      score2_r      <= score2_nxt_s;
      hand_value_r  <= hand_value_nxt_s;
      trick_idx_r   <= trick_idx_nxt_s;
      res_r         <= res_nxt_s;
      last_raiser_r <= last_raiser_nxt_s;
      requester_r   <= requester_nxt_s;
      award_team_r  <= award_team_nxt_s;
      bet_pending_r <= bet_pending_nxt_s;
      hand_done_r   <= hand_done_nxt_s;
      hand_winner_r <= hand_winner_nxt_s;
      game_over_r   <= game_over_nxt_s;
      game_winner_r <= game_winner_nxt_s;
    end
  end

  assign score1      = score1_r;
  assign score2      = score2_r;
  assign hand_value  = hand_value_r;
  assign trick_idx   = trick_idx_r;
  assign bet_pending = bet_pending_r;
  assign hand_done   = hand_done_r;
  assign hand_winner = hand_winner_r;
  assign game_over   = game_over_r;
  assign game_winner = game_winner_r;

endmodule

// File: tb/tb_truco_hand_ctrl.sv
// -----------------------------------------------------------------------------
// tb_truco_hand_ctrl
// Directed bench for truco_hand_ctrl. A game model (trick list, win counting,
// stake ladder, award delay) steps on every rising edge; a compare process
// checks every DUT output against it on each falling edge, and the stimulus
// sequence adds hand-computed literal expectations at key points.
// -----------------------------------------------------------------------------
module tb_truco_hand_ctrl;

  localparam int WIN = 12;

  logic       clk;
  logic       clr;
  logic       trick_valid;
  logic [1:0] trick_winner;
  logic       bet_req;
  logic [1:0] bet_team;
  logic       bet_accept;
  logic       bet_fold;
  logic       new_game;
  logic [4:0] score1;
  logic [4:0] score2;
  logic [3:0] hand_value;
  logic [1:0] trick_idx;
  logic       bet_pending;
  logic       hand_done;
  logic [1:0] hand_winner;
  logic       game_over;
  logic [1:0] game_winner;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  truco_hand_ctrl #(.WIN_SCORE(12), .SCORE_W(5)) dut (
    .clk          (clk),
    .clr          (clr),
    .trick_valid  (trick_valid),
    .trick_winner (trick_winner),
    .bet_req      (bet_req),
    .bet_team     (bet_team),
    .bet_accept   (bet_accept),
    .bet_fold     (bet_fold),
    .new_game     (new_game),
    .score1       (score1),
    .score2       (score2),
    .hand_value   (hand_value),
    .trick_idx    (trick_idx),
    .bet_pending  (bet_pending),
    .hand_done    (hand_done),
    .hand_winner  (hand_winner),
    .game_over    (game_over),
    .game_winner  (game_winner)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- checking helper ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- game model ----------------
  // Team codes: 1 = team1, 2 = team2, 3 = tie.
  int m_s1, m_s2, m_val, m_idx, m_last, m_req, m_award_win, m_hwin, m_gwin;
  bit m_pend, m_award, m_done, m_over;
  int m_tricks[$];

  // Hand result from the list of played tricks: -1 undecided, 0 void, 1/2 winner.
  function automatic int judge_hand(input int q[$]);
    int w1 = 0;
    int w2 = 0;
    bit any_tie = 1'b0;
    int first = 0;
    foreach (q[i]) begin
      if (q[i] == 1) w1++;
      else if (q[i] == 2) w2++;
      else any_tie = 1'b1;
      if (first == 0 && q[i] != 3) first = q[i];
    end
    if (w1 >= 2) return 1;
    if (w2 >= 2) return 2;
    if (q.size() >= 2 && any_tie) begin
      if (first != 0) return first;
      if (q.size() == 3) return 0;
    end
    return -1;
  endfunction

  function automatic int next_val(input int v);
    int ladder[5] = '{1, 3, 6, 9, 12};
    for (int i = 0; i < 4; i++) begin
      if (ladder[i] == v) return ladder[i + 1];
    end
    return v;
  endfunction

  task automatic model_reset();
    m_s1 = 0; m_s2 = 0; m_val = 1; m_idx = 0; m_last = 0; m_req = 0;
    m_award_win = 0; m_hwin = 0; m_gwin = 0;
    m_pend = 1'b0; m_award = 1'b0; m_done = 1'b0; m_over = 1'b0;
    m_tricks.delete();
  endtask

  task automatic model_step();
    int r;
    if (clr) begin
      model_reset();
    end else begin
      m_done = 1'b0;
      m_hwin = 0;
      if (m_over) begin
        if (new_game) begin
          m_s1 = 0; m_s2 = 0; m_over = 1'b0; m_gwin = 0;
        end
      end else if (m_award) begin
        if (m_award_win == 1) m_s1 = (m_s1 + m_val > WIN) ? WIN : m_s1 + m_val;
        if (m_award_win == 2) m_s2 = (m_s2 + m_val > WIN) ? WIN : m_s2 + m_val;
        m_done = 1'b1;
        m_hwin = m_award_win;
        m_award = 1'b0;
        m_val = 1; m_idx = 0; m_last = 0;
        m_tricks.delete();
        if (m_s1 >= WIN) begin m_over = 1'b1; m_gwin = 1; end
        else if (m_s2 >= WIN) begin m_over = 1'b1; m_gwin = 2; end
      end else if (m_pend) begin
        if (bet_fold) begin
          m_award = 1'b1; m_award_win = m_req; m_pend = 1'b0;
        end else if (bet_accept) begin
          m_val = next_val(m_val); m_last = m_req; m_pend = 1'b0;
        end
      end else begin
        if (trick_valid) begin
          if (trick_winner != 2'b00) begin
            m_tricks.push_back(int'(trick_winner));
            r = judge_hand(m_tricks);
            if (r < 0) m_idx++;
            else begin m_award = 1'b1; m_award_win = r; end
          end
        end else if (bet_req && (bet_team == 2'b01 || bet_team == 2'b10) &&
                     m_val < 12 && int'(bet_team) != m_last) begin
          m_pend = 1'b1;
          m_req  = int'(bet_team);
        end
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  // Compare every output against the model on each falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        chk("score1",      score1,      m_s1);
        chk("score2",      score2,      m_s2);
        chk("hand_value",  hand_value,  m_val);
        chk("trick_idx",   trick_idx,   m_idx);
        chk("bet_pending", bet_pending, 32'(m_pend));
        chk("hand_done",   hand_done,   32'(m_done));
        chk("hand_winner", hand_winner, m_hwin);
        chk("game_over",   game_over,   32'(m_over));
        chk("game_winner", game_winner, m_gwin);
      end
    end
  end

  // ---------------- stimulus helpers (entered and left on a falling edge) ----------------
  task automatic drive(input bit tv, input int tw, input bit br, input int bt,
                       input bit ba, input bit bf, input bit ng, input bit rs);
    trick_valid  = tv;
    trick_winner = 2'(tw);
    bet_req      = br;
    bet_team     = 2'(bt);
    bet_accept   = ba;
    bet_fold     = bf;
    new_game     = ng;
    clr          = rs;
    @(negedge clk);
    trick_valid = 1'b0; trick_winner = 2'b00; bet_req = 1'b0; bet_team = 2'b00;
    bet_accept = 1'b0; bet_fold = 1'b0; new_game = 1'b0; clr = 1'b0;
  endtask

  task automatic trick(input int c);  drive(1'b1, c, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0); endtask
  task automatic req(input int t);    drive(1'b0, 0, 1'b1, t, 1'b0, 1'b0, 1'b0, 1'b0); endtask
  task automatic acc();               drive(1'b0, 0, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0); endtask
  task automatic newg();              drive(1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b0); endtask
  task automatic idle(input int n);   repeat (n) @(negedge clk); endtask
  task automatic raise(input int t);  req(t); acc(); endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  // ---------------- directed sequence ----------------
  initial begin
    clr = 1'b1; trick_valid = 1'b0; trick_winner = 2'b00; bet_req = 1'b0;
    bet_team = 2'b00; bet_accept = 1'b0; bet_fold = 1'b0; new_game = 1'b0;
    idle(2);
    clr = 1'b0;
    cmp_en = 1'b1;
    chk("reset score1", score1, 0);
    chk("reset score2", score2, 0);
    chk("reset hand_value", hand_value, 1);
    chk("reset trick_idx", trick_idx, 0);
    chk("reset game_over", game_over, 0);

    // Two straight team1 tricks.
    trick(1);
    chk("t1 trick_idx after first", trick_idx, 1);
    trick(1);
    chk("t1 no early score", score1, 0);
    idle(1);
    chk("t1 score1", score1, 1);
    chk("t1 hand_done", hand_done, 1);
    chk("t1 hand_winner", hand_winner, 1);
    chk("t1 trick_idx", trick_idx, 0);
    idle(1);
    chk("t1 hand_done pulse end", hand_done, 0);

    // Tied first trick, team2 takes the next.
    trick(3);
    trick(2);
    idle(1);
    chk("tie-t2 score2", score2, 1);
    chk("tie-t2 hand_winner", hand_winner, 2);

    // All three tied: void hand.
    trick(3); trick(3); trick(3);
    idle(1);
    chk("void hand_done", hand_done, 1);
    chk("void hand_winner", hand_winner, 0);
    chk("void score1", score1, 1);
    chk("void score2", score2, 1);

    // Trick0 winner protected by a later tie; split then tie; ignored code.
    trick(1); trick(3); idle(1);
    chk("t1-tie score1", score1, 2);
    trick(0);
    chk("code00 ignored", trick_idx, 0);
    trick(2); trick(1); trick(3); idle(1);
    chk("split-tie score2", score2, 2);

    // Raise handshake and fold priority.
    req(1);
    chk("bet pending", bet_pending, 1);
    acc();
    chk("raised to 3", hand_value, 3);
    req(1);
    chk("same raiser ignored", bet_pending, 0);
    req(2);
    drive(1'b0, 0, 1'b0, 0, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(1);
    chk("fold score2 +3", score2, 5);
    chk("fold hand_value reset", hand_value, 1);

    // Raise to the top, extra raise ignored, team2 wins and ends the game.
    raise(1); raise(2); raise(1); raise(2);
    chk("ladder top", hand_value, 12);
    req(1);
    chk("raise at 12 ignored", bet_pending, 0);
    trick(2); trick(1); trick(2); idle(1);
    chk("t2 saturated", score2, 12);
    chk("game_over t2", game_over, 1);
    chk("game_winner t2", game_winner, 2);
    idle(1);
    trick(1);
    chk("game over holds score1", score1, 2);
    chk("game over holds flag", game_over, 1);
    newg();
    chk("new_game score2", score2, 0);
    chk("new_game game_over", game_over, 0);

    // Build team1 to 10, then a 3-point hand saturates at 12.
    raise(1); raise(2); raise(1);
    trick(1); trick(1); idle(1);
    chk("nine point hand", score1, 9);
    trick(2); trick(1); trick(1); idle(1);
    chk("score1 at 10", score1, 10);
    raise(1);
    trick(1); trick(1); idle(1);
    chk("t1 saturated", score1, 12);
    chk("game_winner t1", game_winner, 1);
    idle(2);
    newg();
    chk("new_game score1", score1, 0);

    // Clear in the middle of a raise at stake 6.
    trick(2); trick(2); idle(1);
    raise(1); raise(2);
    req(1);
    chk("pending at 6", hand_value, 6);
    drive(1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("clr score2", score2, 0);
    chk("clr hand_value", hand_value, 1);
    chk("clr bet_pending", bet_pending, 0);

    // Simultaneous trick and raise: the trick is taken, the raise dropped.
    drive(1'b1, 1, 1'b1, 1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("same-cycle trick_idx", trick_idx, 1);
    chk("same-cycle bet dropped", bet_pending, 0);
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
